// File: rtl/calc_fsm.sv
// calc_fsm: matrix calculator control FSM (ports: clk, rst, btn_confirm, btn_back, sw_mode[1:0], op_sel[3:0], *_done, compute_err -> state[3:0], op_type[3:0], start); optional CALC_FSM_WATCHDOG_EN
module calc_fsm #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned WAIT_SEC    = 10,
  parameter int unsigned WDOG_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_confirm,
  input  logic       btn_back,
  input  logic [1:0] sw_mode,
  input  logic [3:0] op_sel,
  input  logic       input_done,
  input  logic       gen_done,
  input  logic       display_done,
  input  logic       store_done,
  input  logic       compute_done,
  input  logic       compute_err,
  output logic [3:0] state,
  output logic [3:0] op_type,
  output logic       start
);
  typedef enum logic [3:0] {
    S0_IDLE = 4'd0, S1_MENU = 4'd1, S2_INPUT = 4'd2, S3_GEN = 4'd3, S4_DISPLAY = 4'd4,
    S5_COMPUTE = 4'd5, S6_ERROR = 4'd6, S7_STORE = 4'd7, S8_OPSEL = 4'd8, S9_WAIT = 4'd9
  } state_t;
  localparam int unsigned WAIT_N = CLK_HZ * WAIT_SEC;
  localparam int WAIT_W = WAIT_N > 1 ? $clog2(WAIT_N) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_N - 1);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic start_q, start_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic sel_ok, live;
  state_t menu_tgt;
  assign sel_ok = (op_sel != 4'd0) && ((op_sel & (op_sel - 4'd1)) == 4'd0);
  // done/error pulses are masked in a state's entry cycle, which is exactly when start is high
  assign live = !start_q;
  assign menu_tgt = sw_mode == 2'd0 ? S2_INPUT : sw_mode == 2'd1 ? S3_GEN : sw_mode == 2'd2 ? S4_DISPLAY : S8_OPSEL;
`ifdef CALC_FSM_WATCHDOG_EN
  localparam int WDOG_W = WDOG_CYCLES > 1 ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic wd_state;
  assign wd_state = state_q inside {S2_INPUT, S3_GEN, S5_COMPUTE, S7_STORE};
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    case (state_q)
      S0_IDLE: state_d = btn_confirm ? S1_MENU : S0_IDLE;
      S1_MENU: state_d = btn_back ? S0_IDLE : btn_confirm ? menu_tgt : S1_MENU;
      S2_INPUT: state_d = live && input_done ? S7_STORE : S2_INPUT;
      S3_GEN: state_d = live && gen_done ? S7_STORE : S3_GEN;
      S7_STORE: state_d = live && store_done ? S1_MENU : S7_STORE;
      S4_DISPLAY: state_d = btn_back || (live && display_done) ? S1_MENU : S4_DISPLAY;
      S5_COMPUTE: state_d = !live ? S5_COMPUTE : compute_err ? S6_ERROR : compute_done ? S4_DISPLAY : S5_COMPUTE;
      S6_ERROR: state_d = btn_confirm ? S9_WAIT : S6_ERROR;
      S8_OPSEL: begin
        op_d = sel_ok ? op_sel : 4'd0;
        state_d = btn_back ? S1_MENU : btn_confirm ? (sel_ok ? S5_COMPUTE : S6_ERROR) : S8_OPSEL;
      end
      S9_WAIT: state_d = btn_back ? S1_MENU : wait_q == WAIT_LAST ? S8_OPSEL : S9_WAIT;
      default: state_d = S0_IDLE;
    endcase
`ifdef CALC_FSM_WATCHDOG_EN
    // a done pulse that already moved the state wins over the timeout
    if (wd_state && state_d == state_q && wdog_q == WDOG_LAST) state_d = S6_ERROR;
    wdog_d = wd_state && state_d == state_q ? wdog_q + 1'b1 : '0;
`endif
    if (state_d inside {S0_IDLE, S1_MENU}) op_d = 4'd0;
    start_d = state_d != state_q && state_d inside {S2_INPUT, S3_GEN, S4_DISPLAY, S5_COMPUTE, S7_STORE};
    // counter is zero on the S9 entry cycle and saturates rather than wrapping
    wait_d = state_q != S9_WAIT ? '0 : wait_q == WAIT_LAST ? wait_q : wait_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0_IDLE;
      op_q <= 4'd0;
      start_q <= 1'b0;
      wait_q <= '0;
`ifdef CALC_FSM_WATCHDOG_EN
      wdog_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      start_q <= start_d;
      wait_q <= wait_d;
`ifdef CALC_FSM_WATCHDOG_EN
      wdog_q <= wdog_d;
`endif
    end
  end
  assign state = state_q;
  assign op_type = op_q;
  assign start = start_q;
endmodule

// File: tb/tb_calc_fsm.sv
// tb_calc_fsm: directed self-checking bench for calc_fsm
module tb_calc_fsm;
  logic clk = 1'b0;
  logic rst, btn_confirm, btn_back;
  logic [1:0] sw_mode;
  logic [3:0] op_sel;
  logic input_done, gen_done, display_done, store_done, compute_done, compute_err;
  logic [3:0] state, op_type;
  logic start;
  int cmp = 0;
  int mism = 0;
  calc_fsm #(.CLK_HZ(10), .WAIT_SEC(3), .WDOG_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .btn_confirm(btn_confirm), .btn_back(btn_back), .sw_mode(sw_mode),
    .op_sel(op_sel), .input_done(input_done), .gen_done(gen_done), .display_done(display_done),
    .store_done(store_done), .compute_done(compute_done), .compute_err(compute_err),
    .state(state), .op_type(op_type), .start(start)
  );
  always #5 clk = ~clk;
  task tick;
    @(negedge clk);
  endtask
  task press(input logic c, input logic b);
    btn_confirm = c;
    btn_back = b;
    tick;
    btn_confirm = 1'b0;
    btn_back = 1'b0;
  endtask
  task test_reset;
    rst = 1'b1;
    btn_confirm = 0; btn_back = 0; sw_mode = 0; op_sel = 0;
    input_done = 0; gen_done = 0; display_done = 0; store_done = 0; compute_done = 0; compute_err = 0;
    tick; tick;
    rst = 1'b0;
    cmp++; if (state !== 4'd0) begin mism++; $display("FAIL reset_state got=%0d exp=0", state); end
    cmp++; if (op_type !== 4'd0) begin mism++; $display("FAIL reset_op got=%b exp=0000", op_type); end
    cmp++; if (start !== 1'b0) begin mism++; $display("FAIL reset_start got=%b exp=0", start); end
  endtask
  task test_gen_store;
    press(1, 0);
    cmp++; if (state !== 4'd1 || start !== 1'b0) begin mism++; $display("FAIL gen_menu state=%0d start=%b exp=1/0", state, start); end
    sw_mode = 2'd1;
    press(1, 0);
    cmp++; if (state !== 4'd3 || start !== 1'b1) begin mism++; $display("FAIL gen_enter state=%0d start=%b exp=3/1", state, start); end
    press(0, 1);
    cmp++; if (state !== 4'd3 || start !== 1'b0) begin mism++; $display("FAIL gen_back_ignored state=%0d start=%b exp=3/0", state, start); end
    repeat (3) tick;
    gen_done = 1; tick; gen_done = 0;
    cmp++; if (state !== 4'd7 || start !== 1'b1) begin mism++; $display("FAIL gen_store state=%0d start=%b exp=7/1", state, start); end
    store_done = 1; tick;
    cmp++; if (state !== 4'd7) begin mism++; $display("FAIL store_entry_ignored state=%0d exp=7", state); end
    tick; store_done = 0;
    cmp++; if (state !== 4'd1 || start !== 1'b0) begin mism++; $display("FAIL store_menu state=%0d start=%b exp=1/0", state, start); end
  endtask
  task test_opsel_compute;
    sw_mode = 2'd3;
    press(1, 0);
    cmp++; if (state !== 4'd8 || start !== 1'b0) begin mism++; $display("FAIL opsel_enter state=%0d start=%b exp=8/0", state, start); end
    op_sel = 4'b0100; tick;
    cmp++; if (op_type !== 4'b0100) begin mism++; $display("FAIL opsel_preview got=%b exp=0100", op_type); end
    op_sel = 4'b0110; tick;
    cmp++; if (op_type !== 4'b0000) begin mism++; $display("FAIL opsel_multi_preview got=%b exp=0000", op_type); end
    op_sel = 4'b0100; tick;
    press(1, 0);
    cmp++; if (state !== 4'd5 || start !== 1'b1 || op_type !== 4'b0100) begin mism++; $display("FAIL compute_enter state=%0d start=%b op=%b exp=5/1/0100", state, start, op_type); end
    op_sel = 4'b0001;
    compute_done = 1; tick;
    cmp++; if (state !== 4'd5) begin mism++; $display("FAIL compute_entry_ignored state=%0d exp=5", state); end
    tick; compute_done = 0;
    cmp++; if (state !== 4'd4 || start !== 1'b1 || op_type !== 4'b0100) begin mism++; $display("FAIL display_result state=%0d start=%b op=%b exp=4/1/0100", state, start, op_type); end
    display_done = 1; tick; tick; display_done = 0;
    cmp++; if (state !== 4'd1 || op_type !== 4'b0000) begin mism++; $display("FAIL display_done state=%0d op=%b exp=1/0000", state, op_type); end
  endtask
  task test_error_wait;
    int n;
    sw_mode = 2'd3;
    press(1, 0);
    op_sel = 4'b0110; tick;
    press(1, 0);
    cmp++; if (state !== 4'd6 || op_type !== 4'b0000) begin mism++; $display("FAIL bad_sel_error state=%0d op=%b exp=6/0000", state, op_type); end
    press(1, 0);
    cmp++; if (state !== 4'd9) begin mism++; $display("FAIL error_to_wait state=%0d exp=9", state); end
    n = 0;
    btn_confirm = 1'b1;
    while (state === 4'd9 && n < 100) begin n++; tick; end
    btn_confirm = 1'b0;
    cmp++; if (n !== 30 || state !== 4'd8) begin mism++; $display("FAIL wait_length cycles=%0d state=%0d exp=30/8", n, state); end
    op_sel = 4'b0000; tick;
    press(1, 0);
    press(1, 0);
    repeat (29) tick;
    cmp++; if (state !== 4'd9) begin mism++; $display("FAIL wait_last_cycle state=%0d exp=9", state); end
    press(0, 1);
    cmp++; if (state !== 4'd1) begin mism++; $display("FAIL wait_back_final state=%0d exp=1", state); end
  endtask
  task test_priority;
    sw_mode = 2'd3;
    press(1, 0);
    op_sel = 4'b0001; tick;
    press(1, 0);
    tick;
    compute_done = 1; compute_err = 1; tick; compute_done = 0; compute_err = 0;
    cmp++; if (state !== 4'd6 || op_type !== 4'b0001) begin mism++; $display("FAIL err_over_done state=%0d op=%b exp=6/0001", state, op_type); end
    press(1, 0);
    press(0, 1);
    cmp++; if (state !== 4'd1) begin mism++; $display("FAIL wait_back state=%0d exp=1", state); end
    press(1, 1);
    cmp++; if (state !== 4'd0 || op_type !== 4'b0000) begin mism++; $display("FAIL back_over_confirm state=%0d op=%b exp=0/0000", state, op_type); end
  endtask
  task test_reset_mid;
    press(1, 0);
    sw_mode = 2'd3;
    press(1, 0);
    op_sel = 4'b1000; tick;
    press(1, 0);
    cmp++; if (state !== 4'd5 || op_type !== 4'b1000) begin mism++; $display("FAIL mid_setup state=%0d op=%b exp=5/1000", state, op_type); end
    rst = 1'b1; tick; rst = 1'b0;
    cmp++; if (state !== 4'd0 || op_type !== 4'b0000 || start !== 1'b0) begin mism++; $display("FAIL mid_reset state=%0d op=%b start=%b exp=0/0000/0", state, op_type, start); end
    compute_done = 1; tick; compute_done = 0;
    cmp++; if (state !== 4'd0) begin mism++; $display("FAIL mid_reset_done_ignored state=%0d exp=0", state); end
  endtask
  task test_watchdog;
    int n;
    press(1, 0);
    sw_mode = 2'd1;
    press(1, 0);
    cmp++; if (state !== 4'd3) begin mism++; $display("FAIL wdog_enter state=%0d exp=3", state); end
`ifdef CALC_FSM_WATCHDOG_EN
    n = 0;
    while (state === 4'd3 && n < 100) begin n++; tick; end
    cmp++; if (n !== 20 || state !== 4'd6) begin mism++; $display("FAIL wdog_timeout cycles=%0d state=%0d exp=20/6", n, state); end
`else
    n = 0;
    while (state === 4'd3 && n < 1000) begin n++; tick; end
    cmp++; if (n !== 1000 || state !== 4'd3) begin mism++; $display("FAIL no_wdog_hold cycles=%0d state=%0d exp=1000/3", n, state); end
`endif
  endtask
  initial begin
    test_reset;
    test_gen_store;
    test_opsel_compute;
    test_error_wait;
    test_priority;
    test_reset_mid;
    test_watchdog;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule

// File: doc/calc_fsm.md
# calc_fsm

Top-level control state machine for the matrix calculator. It sequences idle, menu, input, generate, display, compute, error, store, operator-select and wait phases from debounced button pulses and sub-block done/error flags. It drives the 4-bit state code and 4-bit one-hot operator code consumed by `seg_display`, and issues one-cycle start strobes to the datapath blocks.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency in Hz.
- `WAIT_SEC`, default 10: duration of S9_WAIT in seconds. The display counts 9→0 over this period.
- `WDOG_CYCLES`, default 500_000_000: watchdog limit. Used only when the watchdog is compiled in.
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `btn_confirm` in 1: debounced single-cycle confirm pulse.
- `btn_back` in 1: debounced single-cycle back pulse.
- `sw_mode` in 2: menu selection. 0=input, 1=generate, 2=display, 3=operate.
- `op_sel` in 4: operator switches, one-hot. Bit 0=T (transpose), 1=A (add), 2=B (scalar mul), 3=C (matrix mul).
- `input_done`, `gen_done`, `display_done`, `store_done`, `compute_done` in 1 each: sub-block completion pulses.
- `compute_err` in 1: compute failure pulse, e.g. dimension mismatch.
- `state` out 4: current state code.
- `op_type` out 4: operator code.
- `start` out 1: one-cycle strobe on entry to S2, S3, S4, S5 and S7. Consumers qualify it with `state`.

## Operation
State codes: S0_IDLE=0, S1_MENU=1, S2_INPUT=2, S3_GEN=3, S4_DISPLAY=4, S5_COMPUTE=5, S6_ERROR=6, S7_STORE=7, S8_OPSEL=8, S9_WAIT=9. Codes 10–15 are illegal and go to S0 on the next edge.

Transitions:
- S0: confirm → S1.
- S1: back → S0. Confirm → S2, S3, S4 or S8 according to `sw_mode`.
- S2: input_done → S7.
- S3: gen_done → S7.
- S7: store_done → S1.
- S4: display_done or back → S1.
- S8: back → S1. On confirm:
  - `op_sel` has exactly one bit set: latch it into `op_type`, go to S5.
  - otherwise (zero or multiple bits): go to S6.
- S5: compute_err → S6. compute_done → S4, which displays the result.
- S6: confirm → S9.
- S9: back → S1. After a timeout of `CLK_HZ*WAIT_SEC` cycles → S8. Confirm is ignored.

Rules:
- Back takes priority over confirm when both arrive in the same cycle.
- compute_err takes priority over compute_done.
- In S2, S3 and S7, back is ignored.
- Done and error inputs are ignored in the entry cycle of a state, i.e. the cycle in which `start` is high.
- `op_type` in S8 follows `op_sel` live when `op_sel` is one-hot, and is 0 otherwise. This lets the display preview the selection. Outside S8, `op_type` holds the latched value.
- `op_type` clears to 0 on entry to S0 or S1.
- The wait counter is sized with $clog2(CLK_HZ*WAIT_SEC). It clears on every entry to S9 and does not wrap.

## Timing
- All outputs are registered. A qualifying input at edge N produces the new `state` after edge N.
- `start` is high for exactly the first cycle in the new state.
- Reset values: `state`=0, `op_type`=0, `start`=0; wait and watchdog counters=0.
- Reset asserted mid-operation aborts the current phase on the next edge and emits no `start`.
- S9 exits on the edge at which the counter has reached `CLK_HZ*WAIT_SEC-1`, so S9 lasts exactly `CLK_HZ*WAIT_SEC` cycles.
- Back pressed during the final S9 cycle wins and goes to S1.

## Configuration
- `CALC_FSM_WATCHDOG_EN` defined:
  - A counter runs in S2, S3, S5 and S7 and clears on each state entry.
  - After `WDOG_CYCLES` cycles without the expected done pulse, go to S6.
  - A done pulse in the same cycle as the timeout wins.
- `CALC_FSM_WATCHDOG_EN` not defined: these states wait indefinitely and the watchdog logic is absent.

## Test plan
- Reset, then confirm, then `sw_mode`=1 with confirm, then gen_done 5 cycles later, then store_done. Required: state sequence 0→1→3→7→1, with a `start` pulse on the S3 and S7 entries.
- Reach S8 and set `op_sel`=4'b0100. Required: `op_type`=4'b0100 before confirm. Then confirm and compute_done. Required: S5 then S4 with `op_type` still 4'b0100; display_done → S1 with `op_type`=0.
- In S8 with `op_sel`=4'b0110, confirm. Required: S6 and `op_type`=0. Then confirm → S9. With `CLK_HZ`=10 and `WAIT_SEC`=3, S9 lasts exactly 30 cycles, then S8.
- In S5, compute_done and compute_err in the same cycle. Required: S6. In S1, confirm and back together. Required: S0.
- Assert `rst` for one cycle while in S5. Required: S0, `op_type`=0, `start`=0; a subsequent compute_done is ignored.
- With `CALC_FSM_WATCHDOG_EN` and `WDOG_CYCLES`=20: enter S3 with no gen_done. Required: S6 after 20 cycles. Without the macro, the FSM stays in S3 for 1000 cycles.
